// File: rtl/pipeline_pkg.sv
// Shared types and default widths for the unified-memory arbiter.
package pipeline_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_LS
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

endpackage

// File: rtl/arb_pick.sv
// Winner selection for the memory arbiter: LS has priority unless IF has
// been starved for STARVE_MAX consecutive LS grants.
module arb_pick
    import pipeline_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             if_req_i,
    input  logic             ls_req_i,
    input  logic [CNT_W-1:0] starve_i,
    output owner_t           owner_o
);

    always_comb begin
        owner_o = OWN_LS;
        if (if_req_i && (!ls_req_i || starve_i == CNT_W'(STARVE_MAX))) begin
            owner_o = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing unified memory between fetch and load/store.
// Optional read timeout is enabled by defining MEMARB_TIMEOUT_EN.
module mem_arbiter
    import pipeline_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [DATA_W/8-1:0] ls_be,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_f_o,
    output logic                stall_m_o,
    output logic                err_o
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    owner_t           winner;
    logic             tmo_hit;

    arb_pick #(
        .STARVE_MAX(STARVE_MAX),
        .CNT_W     (CNT_W)
    ) u_pick (
        .if_req_i(if_req),
        .ls_req_i(ls_req),
        .starve_i(starve_q),
        .owner_o (winner)
    );

`ifdef MEMARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Counter is held at zero in IDLE so every BUSY entry starts a fresh window.
    always_comb begin
        tmo_d = '0;
        if (state_q != IDLE) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo_hit = (state_q != IDLE) && (tmo_q == TMO_W'(TIMEOUT - 1));
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        if_rdata  = '0;
        ls_rdata  = '0;
        err_o     = 1'b0;

        unique case (state_q)
            IDLE: begin
                mem_req = if_req | ls_req;
                if (mem_req) begin
                    if (winner == OWN_IF) begin
                        mem_be   = '1;
                        mem_addr = if_addr;
                    end else begin
                        mem_we    = ls_we;
                        mem_be    = ls_be;
                        mem_addr  = ls_addr;
                        mem_wdata = ls_wdata;
                    end
                end
                if (mem_req && mem_ready) begin
                    if (winner == OWN_IF) begin
                        if_gnt  = 1'b1;
                        state_d = BUSY_IF;
                    end else begin
                        ls_gnt = 1'b1;
                        if (!ls_we) begin
                            state_d = BUSY_LS;
                        end
                    end
                end
            end
            BUSY_IF: begin
                if (mem_rvalid) begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                    state_d   = IDLE;
                end else if (tmo_hit) begin
                    if_rvalid = 1'b1;
                    err_o     = 1'b1;
                    state_d   = IDLE;
                end
            end
            BUSY_LS: begin
                if (mem_rvalid) begin
                    ls_rvalid = 1'b1;
                    ls_rdata  = mem_rdata;
                    state_d   = IDLE;
                end else if (tmo_hit) begin
                    ls_rvalid = 1'b1;
                    err_o     = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Starvation only accumulates while IF is actually waiting.
        if (!if_req || if_gnt) begin
            starve_d = '0;
        end else if (ls_gnt && starve_q != CNT_W'(STARVE_MAX)) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    assign stall_f_o = if_req & ~if_rvalid;
    assign stall_m_o = ls_req & ~(ls_rvalid | (ls_gnt & ls_we));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter; read data expectations are queued
// per requester when a load is issued and popped when that requester's rvalid fires.
module tb_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall_f_o;
    logic        stall_m_o;
    logic        err_o;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] ifQ[$];
    logic [31:0] lsQ[$];
    logic        respOn = 1'b1;
    logic        accPending;
    logic [31:0] accAddr;

    mem_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_be     (ls_be),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .stall_f_o (stall_f_o),
        .stall_m_o (stall_m_o),
        .err_o     (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] memData(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'd7) ^ 32'hC0DE_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #2;
    endtask

    // Scoreboard pop on rvalid, then model the memory answering one cycle after acceptance.
    task automatic tick();
        logic [31:0] exp;
        if (if_rvalid) begin
            if (ifQ.size() == 0) checkOutput("if_unexpected_rvalid", 32'(if_rvalid), 32'd0);
            else begin
                exp = ifQ.pop_front();
                checkOutput("if_rdata", if_rdata, exp);
            end
        end
        if (ls_rvalid) begin
            if (lsQ.size() == 0) checkOutput("ls_unexpected_rvalid", 32'(ls_rvalid), 32'd0);
            else begin
                exp = lsQ.pop_front();
                checkOutput("ls_rdata", ls_rdata, exp);
            end
        end
        accPending = mem_req & mem_ready & ~mem_we & respOn;
        accAddr    = mem_addr;
        @(posedge clk);
        #1;
        mem_rvalid = accPending;
        mem_rdata  = accPending ? memData(accAddr) : 32'd0;
    endtask

    initial begin
        reset_n    = 1'b0;
        if_req     = 1'b0;
        if_addr    = '0;
        ls_req     = 1'b0;
        ls_we      = 1'b0;
        ls_be      = '0;
        ls_addr    = '0;
        ls_wdata   = '0;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        settle();
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_be", 32'(mem_be), 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_gnts", {30'd0, if_gnt, ls_gnt}, 32'd0);
        checkOutput("rst_rvalids", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
        checkOutput("rst_stalls_err", {29'd0, stall_f_o, stall_m_o, err_o}, 32'd0);
        reset_n = 1'b1;
        tick();

        $display("[TB] fetch read");
        if_req  = 1'b1;
        if_addr = 32'h100;
        ifQ.push_back(32'hDEADBEEF);
        settle();
        checkOutput("fetch_if_gnt", 32'(if_gnt), 32'd1);
        checkOutput("fetch_mem_addr", mem_addr, 32'h100);
        checkOutput("fetch_mem_we_be", {27'd0, mem_we, mem_be}, 32'h0F);
        checkOutput("fetch_stall_f", 32'(stall_f_o), 32'd1);
        tick();
        settle();
        checkOutput("fetch_if_rvalid", 32'(if_rvalid), 32'd1);
        checkOutput("fetch_stall_f_rv", 32'(stall_f_o), 32'd0);
        checkOutput("fetch_busy_mem_req", 32'(mem_req), 32'd0);
        tick();
        if_req = 1'b0;
        settle();
        tick();

        $display("[TB] simultaneous requests");
        if_req  = 1'b1;
        if_addr = 32'h104;
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 32'h200;
        lsQ.push_back(memData(32'h200));
        ifQ.push_back(memData(32'h104));
        settle();
        checkOutput("simul_gnts", {30'd0, if_gnt, ls_gnt}, 32'd1);
        checkOutput("simul_mem_addr", mem_addr, 32'h200);
        checkOutput("simul_stalls", {30'd0, stall_f_o, stall_m_o}, 32'd3);
        tick();
        settle();
        checkOutput("simul_ls_rvalid", 32'(ls_rvalid), 32'd1);
        checkOutput("simul_stall_m_rv", 32'(stall_m_o), 32'd0);
        tick();
        ls_req = 1'b0;
        settle();
        checkOutput("simul_if_gnt_after", 32'(if_gnt), 32'd1);
        checkOutput("simul_if_addr_after", mem_addr, 32'h104);
        tick();
        settle();
        checkOutput("simul_if_rvalid", 32'(if_rvalid), 32'd1);
        tick();
        if_req = 1'b0;
        settle();
        tick();

        $display("[TB] store");
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_be    = 4'b0011;
        ls_addr  = 32'h300;
        ls_wdata = 32'h1234;
        settle();
        checkOutput("store_mem_we_be", {27'd0, mem_we, mem_be}, 32'h13);
        checkOutput("store_mem_wdata", mem_wdata, 32'h1234);
        checkOutput("store_ls_gnt", 32'(ls_gnt), 32'd1);
        checkOutput("store_stall_m", 32'(stall_m_o), 32'd0);
        tick();
        ls_req = 1'b0;
        ls_we  = 1'b0;
        ls_be  = 4'hF;
        settle();
        checkOutput("store_no_rvalid", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
        checkOutput("store_idle_req", 32'(mem_req), 32'd0);
        tick();

        $display("[TB] starvation");
        if_req  = 1'b1;
        if_addr = 32'h108;
        ifQ.push_back(memData(32'h108));
        ls_req  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ls_addr = 32'h400 + 32'(4 * k);
            lsQ.push_back(memData(ls_addr));
            settle();
            checkOutput("starve_ls_wins", {30'd0, if_gnt, ls_gnt}, 32'd1);
            tick();
            settle();
            checkOutput("starve_ls_rvalid", 32'(ls_rvalid), 32'd1);
            tick();
        end
        ls_addr = 32'h410;
        settle();
        checkOutput("starve_if_forced", {30'd0, if_gnt, ls_gnt}, 32'd2);
        checkOutput("starve_if_addr", mem_addr, 32'h108);
        tick();
        settle();
        tick();
        if_req = 1'b0;
        lsQ.push_back(memData(32'h410));
        settle();
        checkOutput("starve_fifth_ls", 32'(ls_gnt), 32'd1);
        tick();
        settle();
        tick();
        ls_req = 1'b0;
        settle();
        tick();

        $display("[TB] delayed response");
        respOn  = 1'b0;
        ls_req  = 1'b1;
        ls_addr = 32'h700;
        settle();
        checkOutput("delay_ls_gnt", 32'(ls_gnt), 32'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            settle();
            checkOutput("delay_wait", {29'd0, err_o, ls_rvalid, stall_m_o}, 32'd1);
            tick();
        end
        lsQ.push_back(memData(32'h700));
        mem_rvalid = 1'b1;
        mem_rdata  = memData(32'h700);
        settle();
        checkOutput("delay_ls_rvalid", 32'(ls_rvalid), 32'd1);
        tick();
        ls_req = 1'b0;
        settle();
        tick();

        $display("[TB] reset during BUSY_LS");
        ls_req  = 1'b1;
        ls_addr = 32'h500;
        settle();
        checkOutput("rstmid_ls_gnt", 32'(ls_gnt), 32'd1);
        tick();
        reset_n = 1'b0;
        ls_req  = 1'b0;
        settle();
        tick();
        reset_n    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0BAD0;
        settle();
        checkOutput("rstmid_no_rvalid", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
        tick();
        respOn  = 1'b1;
        if_req  = 1'b1;
        if_addr = 32'h600;
        ifQ.push_back(memData(32'h600));
        settle();
        checkOutput("rstmid_idle_if_gnt", 32'(if_gnt), 32'd1);
        tick();
        settle();
        tick();
        if_req = 1'b0;
        settle();
        tick();

`ifdef MEMARB_TIMEOUT_EN
        $display("[TB] timeout");
        respOn  = 1'b0;
        ls_req  = 1'b1;
        ls_addr = 32'h800;
        lsQ.push_back(32'd0);
        settle();
        checkOutput("tmo_ls_gnt", 32'(ls_gnt), 32'd1);
        tick();
        for (int k = 0; k < 15; k++) begin
            settle();
            checkOutput("tmo_quiet", {30'd0, err_o, ls_rvalid}, 32'd0);
            tick();
        end
        settle();
        checkOutput("tmo_fire", {30'd0, err_o, ls_rvalid}, 32'd3);
        tick();
        ls_req = 1'b0;
        respOn = 1'b1;
        settle();
        checkOutput("tmo_err_pulse", 32'(err_o), 32'd0);
        tick();
`endif

        checkOutput("ifQ_drained", 32'(ifQ.size()), 32'd0);
        checkOutput("lsQ_drained", 32'(lsQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported unified memory between instruction fetch (IF) and the load/store unit (LS); one outstanding transaction at a time.
- Routes read responses back to the owning requester.
- Emits per-requester stall requests, consumed by the hazard control unit to build StallF/StallD/StallE.
- Sits between the Fetch/Memory pipeline stages and the memory interface.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_MAX, 4, consecutive LS grants allowed while IF waits before IF is forced to win.
- TIMEOUT, 16, cycles to wait for mem_rvalid; used only with MEMARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch read request, held until if_rvalid
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted by memory this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_W  fetch data
- ls_req  in  1  load/store request, held until done
- ls_we  in  1  1 = store
- ls_be  in  DATA_W/8  byte enables
- ls_addr  in  ADDR_W  data address
- ls_wdata  in  DATA_W  store data
- ls_gnt  out  1  LS request accepted this cycle
- ls_rvalid  out  1  load data valid
- ls_rdata  out  DATA_W  load data
- mem_req, mem_we, mem_be, mem_addr, mem_wdata  out  1/1/DATA_W/8/ADDR_W/DATA_W  memory request bus
- mem_ready  in  1  memory accepts request
- mem_rvalid  in  1  read response valid
- mem_rdata  in  DATA_W  read response data
- stall_f_o  out  1  fetch must stall (to hcu)
- stall_m_o  out  1  LS must stall (to hcu)
- err_o  out  1  one-cycle pulse: read timed out

Behaviour:
- States: IDLE, BUSY_IF, BUSY_LS. Reset: state=IDLE, starve counter=0, timeout counter=0.
- Reset values of all outputs: 0. mem_addr, mem_wdata and mem_be are 0 in IDLE with no request.
- IDLE arbitration:
  - mem_req = if_req | ls_req.
  - LS wins, unless starve counter == STARVE_MAX and if_req=1; then IF wins.
  - mem_* buses carry the winner's fields combinationally. IF always drives mem_we=0 and mem_be all-ones.
- Acceptance = mem_req & mem_ready. The winner's gnt pulses in the same cycle.
  - IF read: next state BUSY_IF.
  - LS load: next state BUSY_LS.
  - LS store: complete on acceptance, remain IDLE, no rvalid.
- Starve counter:
  - +1 on each LS acceptance while if_req=1, saturating at STARVE_MAX.
  - Cleared on any IF acceptance, or when if_req=0.
- BUSY_x:
  - mem_req=0.
  - On mem_rvalid: pass mem_rdata to x_rdata, pulse x_rvalid for one cycle, return to IDLE.
  - The next request is issued the following cycle (one idle cycle between reads, by design).
- mem_rvalid in IDLE (stale, e.g. after reset mid-transaction) is ignored; neither rvalid is asserted.
- Stall outputs (combinational):
  - stall_f_o = if_req & ~if_rvalid.
  - stall_m_o = ls_req & ~(ls_rvalid | (ls_gnt & ls_we)).
- Reset mid-transaction: state returns to IDLE immediately; the in-flight response is dropped; requesters re-request.
- Minimum read latency: 2 cycles from request to rvalid, assuming mem_ready=1 and mem_rvalid the next cycle.

Optional Feature:
- MEMARB_TIMEOUT_EN defined:
  - A timeout counter runs in BUSY_x and clears on entry.
  - If TIMEOUT cycles elapse without mem_rvalid: pulse x_rvalid with x_rdata=0, pulse err_o, return to IDLE.
- MEMARB_TIMEOUT_EN undefined: no counter; BUSY_x waits indefinitely; err_o tied 0.

Decomposition:
- Shared package pipeline_pkg:
  - arb_state_t enum {IDLE, BUSY_IF, BUSY_LS}.
  - Owner encoding OWN_IF/OWN_LS.
  - Default widths.
- One natural sub-module: arb_pick (combinational priority plus starve-counter compare producing the winner). Everything else stays in mem_arbiter.

Test Plan:
- Fetch read: if_req=1, if_addr=0x100, mem_ready=1, mem_rvalid a cycle later with 0xDEADBEEF -> if_gnt at cycle 0, if_rvalid and if_rdata=0xDEADBEEF at cycle 1, stall_f_o low in the rvalid cycle.
- Simultaneous requests: if_req=ls_req=1 (load 0x200) -> LS granted first; IF granted on the first IDLE cycle after ls_rvalid.
- Store: ls_req=1, ls_we=1, ls_be=0011, wdata=0x1234 -> mem_we=1 and mem_be=0011 in the accept cycle; ls_gnt=1, stall_m_o=0 in the same cycle; no ls_rvalid.
- Starvation: if_req held, LS issues 5 back-to-back loads -> IF granted after the 4th LS acceptance (STARVE_MAX=4).
- Reset during BUSY_LS: reset_n low for 1 cycle, then mem_rvalid arrives -> no ls_rvalid or if_rvalid; state IDLE.
- With MEMARB_TIMEOUT_EN: load accepted, no mem_rvalid for 16 cycles -> ls_rvalid=1, ls_rdata=0, err_o=1 for one cycle, then IDLE.
